// File: rtl/lcd_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_fetch
//  Brief    : Z88 video fetch engine. Walks the screen base file and the
//             character-generator areas in the blink video slots and emits
//             one decoded glyph row per px_valid strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_fetch #(
    parameter int SCR_W   = 640,
    parameter int MAX_COL = 128
) (
    input  logic        mck,
    input  logic        res,
    input  logic [1:0]  clkcnt,
    input  logic        lcdon,
    input  logic [12:0] pb0w,
    input  logic [9:0]  pb1w,
    input  logic [8:0]  pb2w,
    input  logic [10:0] pb3w,
    input  logic [10:0] sbrw,
    output logic [21:0] va,
    input  logic [7:0]  vid_cdo,
    output logic        px_valid,
    output logic [9:0]  px_x,
    output logic [5:0]  px_y,
    output logic [7:0]  px_bits,
    output logic        px_hires,
    output logic        px_flash,
    output logic        px_grey,
    output logic        frame_done
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_CODE    = 3'd1;
    localparam logic [2:0] c_ST_ATTR    = 3'd2;
    localparam logic [2:0] c_ST_GLYPH   = 3'd3;
    localparam logic [2:0] c_ST_NEXTCH  = 3'd4;
    localparam logic [2:0] c_ST_NEXTROW = 3'd5;

    localparam logic [6:0]  c_COL_LAST = 7'(MAX_COL - 1);
    localparam logic [10:0] c_SCR_W    = 11'(SCR_W);

    // Attribute bit positions
    localparam int c_HRS = 5;
    localparam int c_REV = 4;
    localparam int c_FLS = 3;
    localparam int c_GRY = 2;
    localparam int c_UND = 1;

    logic [2:0]  r_state;
    logic [2:0]  r_row;
    logic [6:0]  r_col;
    logic [2:0]  r_line;
    logic [9:0]  r_x;

    // Start-of-frame copies of the blink base registers
    logic [12:0] r_pb0;
    logic [9:0]  r_pb1;
    logic [8:0]  r_pb2;
    logic [10:0] r_pb3;
    logic [10:0] r_sbr;

    logic [7:0]  r_char;
    logic [5:0]  r_attr;

    logic        r_px_valid;
    logic [9:0]  r_px_x;
    logic [5:0]  r_px_y;
    logic [7:0]  r_px_bits;
    logic        r_px_hires;
    logic        r_px_flash;
    logic        r_px_grey;
    logic        r_frame_done;

    logic        w_slot;
    logic [8:0]  w_lo_code;
    logic [9:0]  w_hi_code;
    logic [3:0]  w_width;
    logic [3:0]  w_new_width;
    logic        w_fits;
    logic [21:0] w_glyph_addr;
    logic [7:0]  w_glyph_data;

    // Only clkcnt 0/1 are video slots; 2 (and the unused 3) freeze the engine
    assign w_slot      = (clkcnt == 2'd0) || (clkcnt == 2'd1);
    assign w_lo_code   = {r_attr[0], r_char};
    assign w_hi_code   = {r_attr[1:0], r_char};
    assign w_width     = r_attr[c_HRS] ? 4'd8 : 4'd6;
    // Width of the glyph whose attribute is being captured right now
    assign w_new_width = vid_cdo[c_HRS] ? 4'd8 : 4'd6;
    assign w_fits      = ({1'b0, r_x} + {7'd0, w_new_width}) <= c_SCR_W;

    // Select the character-generator area and address for the current glyph line
    always_comb begin
        w_glyph_addr = '0;
        if (r_attr[c_HRS]) begin
            if (w_hi_code[9:8] == 2'b11)
                w_glyph_addr = {r_pb3, w_hi_code[7:0], r_line};
            else
                w_glyph_addr = {r_pb2, w_hi_code, r_line};
        end else begin
            if (w_lo_code[8:6] == 3'b111)
                w_glyph_addr = {r_pb0, w_lo_code[5:0], r_line};
            else
                w_glyph_addr = {r_pb1, w_lo_code, r_line};
        end
    end

    // Turn the raw glyph byte into displayed pixels (mask, underline, reverse)
    always_comb begin
        w_glyph_data = vid_cdo;
        if (!r_attr[c_HRS]) begin
            w_glyph_data = {2'b00, vid_cdo[5:0]};
            if (r_attr[c_UND] && (r_line == 3'd7))
                w_glyph_data = 8'h3F;
            if (r_attr[c_REV])
                w_glyph_data = w_glyph_data ^ 8'h3F;
        end else if (r_attr[c_REV]) begin
            w_glyph_data = vid_cdo ^ 8'hFF;
        end
    end

    // Video address depends on registered state only, so it is stable all slot
    always_comb begin
        va = '0;
        case (r_state)
            c_ST_CODE:  va = {r_sbr, r_row, r_col, 1'b0};
            c_ST_ATTR:  va = {r_sbr, r_row, r_col, 1'b1};
            c_ST_GLYPH: va = w_glyph_addr;
            default:    va = '0;
        endcase
    end

    // Fetch sequencer with registered strobes and pixel outputs
    always_ff @(posedge mck or posedge res) begin
        if (res) begin
            r_state      <= c_ST_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_line       <= '0;
            r_x          <= '0;
            r_pb0        <= '0;
            r_pb1        <= '0;
            r_pb2        <= '0;
            r_pb3        <= '0;
            r_sbr        <= '0;
            r_char       <= '0;
            r_attr       <= '0;
            r_px_valid   <= 1'b0;
            r_px_x       <= '0;
            r_px_y       <= '0;
            r_px_bits    <= '0;
            r_px_hires   <= 1'b0;
            r_px_flash   <= 1'b0;
            r_px_grey    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_px_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (lcdon) begin
                        r_pb0   <= pb0w;
                        r_pb1   <= pb1w;
                        r_pb2   <= pb2w;
                        r_pb3   <= pb3w;
                        r_sbr   <= sbrw;
                        r_state <= c_ST_CODE;
                    end
                end
                c_ST_CODE: begin
                    if (w_slot) begin
                        r_char  <= vid_cdo;
                        r_state <= c_ST_ATTR;
                    end
                end
                c_ST_ATTR: begin
                    if (w_slot) begin
                        r_attr  <= vid_cdo[5:0];
                        r_line  <= '0;
                        r_state <= w_fits ? c_ST_GLYPH : c_ST_NEXTROW;
                    end
                end
                c_ST_GLYPH: begin
                    if (w_slot) begin
                        r_px_valid <= 1'b1;
                        r_px_x     <= r_x;
                        r_px_y     <= {r_row, r_line};
                        r_px_bits  <= w_glyph_data;
                        r_px_hires <= r_attr[c_HRS];
                        r_px_flash <= r_attr[c_FLS];
                        r_px_grey  <= r_attr[c_GRY];
                        r_line     <= r_line + 3'd1;
                        if (r_line == 3'd7)
                            r_state <= c_ST_NEXTCH;
                    end
                end
                c_ST_NEXTCH: begin
                    r_x <= r_x + {6'd0, w_width};
                    if (r_col == c_COL_LAST) begin
                        r_col   <= '0;
                        r_state <= c_ST_NEXTROW;
                    end else begin
                        r_col   <= r_col + 7'd1;
                        r_state <= c_ST_CODE;
                    end
                end
                c_ST_NEXTROW: begin
                    r_col <= '0;
                    r_x   <= '0;
                    if (r_row == 3'd7) begin
                        r_row        <= '0;
                        r_frame_done <= 1'b1;
                        r_state      <= c_ST_IDLE;
                    end else begin
                        r_row   <= r_row + 3'd1;
                        r_state <= c_ST_CODE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign px_valid   = r_px_valid;
    assign px_x       = r_px_x;
    assign px_y       = r_px_y;
    assign px_bits    = r_px_bits;
    assign px_hires   = r_px_hires;
    assign px_flash   = r_px_flash;
    assign px_grey    = r_px_grey;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
